// File: rtl/fifo_sync_pkg.sv
// Shared sizing helpers, reset values and parameter legality checks for fifo_sync.
// Optional first-word-fall-through is selected with the FIFO_SYNC_FWFT_EN macro.
package fifo_sync_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the level can represent DEPTH itself.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit cfg_ok(input int width, input int depth, input int af, input int ae);
    return (width >= 1) && is_pow2(depth) && (depth >= 4) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

  localparam logic RST_EMPTY = 1'b1;
  localparam logic RST_FULL  = 1'b0;
  localparam logic RST_AE    = 1'b1;
  localparam logic RST_AF    = 1'b0;
  localparam logic RST_ERR   = 1'b0;

endpackage

// File: rtl/fifo_sync_mem.sv
// WIDTH x DEPTH storage for fifo_sync: one synchronous write port and one read port,
// registered by default, combinational when FIFO_SYNC_FWFT_EN is defined.
module fifo_sync_mem
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_SYNC_FWFT_EN
  logic unused_rd_ctrl;
  assign unused_rd_ctrl = rst ^ re;
  assign rdata = mem[raddr];
`else
  // Output word is reset to zero and only changes on an accepted read.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with level, almost flags and sticky overflow/underflow errors.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through; standard 1-cycle read latency otherwise.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 128,
  parameter int AF_LEVEL = 124,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     insert,
  input  logic                     remove,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         dataIn,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  if (!cfg_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_cfg
    $error("fifo_sync: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_nxt;
  logic             rd_acc, wr_acc;
  logic             mem_we, mem_re;
  logic [WIDTH-1:0] mem_rdata;

  // A same-cycle read frees the slot, so a full FIFO still takes the write.
  assign rd_acc = remove & ~empty;
  assign wr_acc = insert & (~full | rd_acc);
  assign mem_we = wr_acc & ~flush;
  assign mem_re = rd_acc & ~flush;

  always_comb begin
    level_nxt = level_q;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   level_nxt = level_q + LW'(1);
        2'b01:   level_nxt = level_q - LW'(1);
        default: level_nxt = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      empty        <= RST_EMPTY;
      full         <= RST_FULL;
      almost_empty <= RST_AE;
      almost_full  <= RST_AF;
      overflow     <= RST_ERR;
      underflow    <= RST_ERR;
    end else begin
      level_q      <= level_nxt;
      empty        <= (level_nxt == '0);
      full         <= (level_nxt == LW'(DEPTH));
      almost_full  <= (level_nxt >= LW'(AF_LEVEL));
      almost_empty <= (level_nxt <= LW'(AE_LEVEL));
      if (flush) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        overflow  <= RST_ERR;
        underflow <= RST_ERR;
      end else begin
        if (wr_acc)            wr_ptr_q  <= wr_ptr_q + AW'(1);
        if (rd_acc)            rd_ptr_q  <= rd_ptr_q + AW'(1);
        if (insert && !wr_acc) overflow  <= 1'b1;
        if (remove && !rd_acc) underflow <= 1'b1;
      end
    end
  end

  assign level = level_q;

  fifo_sync_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_in (clk_in),
    .rst    (rst),
    .we     (mem_we),
    .waddr  (wr_ptr_q),
    .wdata  (dataIn),
    .re     (mem_re),
    .raddr  (rd_ptr_q),
    .rdata  (mem_rdata)
  );

`ifdef FIFO_SYNC_FWFT_EN
  // Keeps the last popped word on the output while the FIFO is empty.
  logic [WIDTH-1:0] hold_q;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)        hold_q <= '0;
    else if (mem_re) hold_q <= mem_rdata;
  end

  assign dataOut = empty ? hold_q : mem_rdata;
`else
  assign dataOut = mem_rdata;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: queue-based reference model checked every cycle,
// plus literal expectations at the interesting boundaries.
module tb_fifo_sync;

  localparam int WIDTH = 32;
  localparam int DEPTH = 128;
  localparam int AFL   = 124;
  localparam int AEL   = 4;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             insert, remove, flush;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;
  logic [7:0]       level;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  logic [WIDTH-1:0] q [$];
  logic             m_ovf, m_unf;
  logic [WIDTH-1:0] m_last;

  fifo_sync #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AFL),
    .AE_LEVEL (AEL)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .insert       (insert),
    .remove       (remove),
    .flush        (flush),
    .dataIn       (dataIn),
    .dataOut      (dataOut),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_dout();
`ifdef FIFO_SYNC_FWFT_EN
    return (q.size() > 0) ? q[0] : m_last;
`else
    return m_last;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_last = '0;
  endtask

  // Behaviour of one clock edge, stated in terms of the queue contents.
  task automatic model_step(input bit ins, input bit rem, input bit fl, input logic [WIDTH-1:0] d);
    bit rd_ok, wr_ok;
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd_ok = rem && (q.size() > 0);
      wr_ok = ins && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) m_last = q.pop_front();
      if (wr_ok) q.push_back(d);
      if (ins && !wr_ok) m_ovf = 1'b1;
      if (rem && !rd_ok) m_unf = 1'b1;
    end
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      check("level",        32'(level),        32'(q.size()));
      check("empty",        32'(empty),        32'(q.size() == 0));
      check("full",         32'(full),         32'(q.size() == DEPTH));
      check("almost_full",  32'(almost_full),  32'(q.size() >= AFL));
      check("almost_empty", 32'(almost_empty), 32'(q.size() <= AEL));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("underflow",    32'(underflow),    32'(m_unf));
      check("dataOut",      dataOut,           model_dout());
    end
  end

  task automatic cycle(input bit ins, input bit rem, input bit fl, input logic [WIDTH-1:0] d);
    insert = ins;
    remove = rem;
    flush  = fl;
    dataIn = d;
    @(posedge clk_in);
    model_step(ins, rem, fl, d);
    @(negedge clk_in);
    #1;
    insert = 1'b0;
    remove = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"},   32'(empty),        32'd1);
    check({tag, "_full"},    32'(full),         32'd0);
    check({tag, "_level"},   32'(level),        32'd0);
    check({tag, "_ae"},      32'(almost_empty), 32'd1);
    check({tag, "_af"},      32'(almost_full),  32'd0);
    check({tag, "_ovf"},     32'(overflow),     32'd0);
    check({tag, "_unf"},     32'(underflow),    32'd0);
    check({tag, "_dataOut"}, dataOut,           32'd0);
  endtask

  initial begin
    rst    = 1'b0;
    insert = 1'b0;
    remove = 1'b0;
    flush  = 1'b0;
    dataIn = '0;
    model_reset();
    repeat (2) @(negedge clk_in);
    #1;
    check_reset_state("por");
    chk_en = 1'b1;
    rst    = 1'b1;

    // Reset in the middle of traffic: underflow set, 5 words in, one read out.
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 32'h11 + i);
    cycle(0, 1, 0, 0);
`ifndef FIFO_SYNC_FWFT_EN
    check("pre_rst_dout", dataOut, 32'h11);
`endif
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_state("mid_rst");
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    rst = 1'b1;

    // Fill to full, one rejected insert, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, i);
    cycle(1, 0, 0, 32'h3E7);
    check("fill_full",  32'(full),     32'd1);
    check("fill_level", 32'(level),    32'd128);
    check("fill_ovf",   32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
`ifdef FIFO_SYNC_FWFT_EN
      check("drain_data", dataOut, i);
      cycle(0, 1, 0, 0);
`else
      cycle(0, 1, 0, 0);
      check("drain_data", dataOut, i);
`endif
    end
    check("drain_empty", 32'(empty),    32'd1);
    check("drain_ovf",   32'(overflow), 32'd1);

    // Read on empty with a simultaneous insert.
    cycle(0, 0, 1, 0);
    cycle(1, 1, 0, 32'hA5);
    check("ufw_unf",   32'(underflow), 32'd1);
    check("ufw_level", 32'(level),     32'd1);
`ifdef FIFO_SYNC_FWFT_EN
    check("ufw_data", dataOut, 32'hA5);
    cycle(0, 1, 0, 0);
`else
    cycle(0, 1, 0, 0);
    check("ufw_data", dataOut, 32'hA5);
`endif

    // Sustained insert+remove at full across many pointer wraps.
    cycle(0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 1000 + i);
    for (int k = 0; k < 300; k++) cycle(1, 1, 0, 2000 + k);
    check("steady_full",  32'(full),     32'd1);
    check("steady_level", 32'(level),    32'd128);
    check("steady_ovf",   32'(overflow), 32'd0);
`ifdef FIFO_SYNC_FWFT_EN
    check("steady_data", dataOut, 32'd2172);
`else
    check("steady_data", dataOut, 32'd2171);
`endif

    // Almost-full threshold around 124, almost-empty around 4.
    cycle(0, 0, 1, 0);
    for (int i = 0; i < AFL - 1; i++) cycle(1, 0, 0, 500 + i);
    check("af_123", 32'(almost_full), 32'd0);
    cycle(1, 0, 0, 32'h777);
    check("af_124",     32'(almost_full), 32'd1);
    check("af_124_lvl", 32'(level),       32'd124);
    cycle(0, 1, 0, 0);
    check("af_back_123", 32'(almost_full), 32'd0);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < AEL; i++) cycle(1, 0, 0, 600 + i);
    check("ae_4", 32'(almost_empty), 32'd1);
    cycle(1, 0, 0, 32'h604);
    check("ae_5", 32'(almost_empty), 32'd0);
    cycle(0, 1, 0, 0);
    check("ae_back_4", 32'(almost_empty), 32'd1);

    // Flush with a competing insert at level 10.
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 50 + i);
    cycle(1, 0, 1, 32'hDEAD);
    check("flush_level", 32'(level),     32'd0);
    check("flush_empty", 32'(empty),     32'd1);
    check("flush_unf",   32'(underflow), 32'd0);
    cycle(1, 0, 0, 32'h77);
`ifdef FIFO_SYNC_FWFT_EN
    check("post_flush_data", dataOut, 32'h77);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 32'h1234);
    check("fwft_data", dataOut, 32'h1234);
`else
    cycle(0, 1, 0, 0);
    check("post_flush_data", dataOut, 32'h77);
`endif

    repeat (2) @(negedge clk_in);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Parametrised single-clock FIFO, the next generation of the team's serial-bit FIFO: configurable data width and depth, occupancy level, programmable almost-full/almost-empty flags, sticky overflow/underflow errors and optional first-word-fall-through. It buffers parallel words between the producer and the parallel-to-serial shifter where both sides share one clock.

## Interface
- WIDTH, 32: data word width in bits, ≥1.
- DEPTH, 128: entries; power of two, ≥4.
- AF_LEVEL, 124: almost_full asserts when level ≥ AF_LEVEL; 1..DEPTH.
- AE_LEVEL, 4: almost_empty asserts when level ≤ AE_LEVEL; 0..DEPTH-1.
- clk_in  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- insert  input  1  write request.
- remove  input  1  read/pop request.
- flush  input  1  synchronous clear.
- dataIn  input  WIDTH  write data.
- dataOut  output  WIDTH  read data.
- full, empty  output  1  status.
- almost_full, almost_empty  output  1  threshold status.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow, underflow  output  1  sticky error flags.

## Operation
- Reset (rst=0, asynchronous): pointers=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dataOut=0.
- Write accepted when insert=1 and (full=0 or remove accepted same cycle); dataIn stored at write pointer.
- Read accepted when remove=1 and empty=0; an insert in the same cycle never makes a read on an empty FIFO legal.
- Rejected insert: no state change, overflow set. Rejected remove: no state change, underflow set. Both sticky until reset or flush.
- Simultaneous accepted insert+remove: level unchanged; at full both succeed, full stays 1.
- flush=1: pointers=0, level=0, flags to reset values, overflow/underflow cleared; takes priority over insert/remove that cycle; dataOut holds its value (standard mode).
- Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 → 0 naturally; full/empty derived from level (level==DEPTH / level==0).
- All status outputs are registered, derived from next-state level.

## Timing
- Standard mode: accepted remove at edge N → dataOut valid after edge N (1-cycle read latency); dataOut holds between reads.
- Write at edge N → empty=0, level incremented after edge N; earliest read at edge N+1.
- Write-to-read throughput: one word per cycle sustained, including at full and at empty boundaries (empty: write only; full: read, or read+write).
- level/full/empty/almost_* update on the same edge as the accepted operation; no combinational path from insert/remove to status outputs.

## Configuration
- FIFO_SYNC_FWFT_EN defined: first-word-fall-through; dataOut shows the head entry whenever empty=0 (valid after the writing edge of an empty FIFO), remove pops and dataOut shows the next entry after that edge; dataOut is don't-care-but-stable (last value) when empty=1.
- Undefined: standard mode as above.

## Structure
- Package fifo_sync_pkg: ptr/level width functions (clog2-based), reset constants, checks that DEPTH is a power of two and thresholds are in range.
- Sub-module fifo_sync_mem: WIDTH×DEPTH register array, one synchronous write port, one read port (registered in standard mode, combinational in FWFT). Control, level and flags in fifo_sync.

## Test plan
- Reset mid-stream: 5 writes, assert rst=0 mid-cycle → immediately empty=1, level=0, dataOut=0, flags cleared.
- Fill 128 words 0..127, one extra insert → full=1, level=128, overflow=1, word 127 intact; drain → 0..127 in order, empty=1 after 128th read.
- Read on empty with simultaneous insert of 0xA5 → underflow=1, level=1, next read returns 0xA5.
- At full, insert+remove each cycle for 300 cycles → full stays 1, level 128, data order preserved across pointer wrap.
- Thresholds: write to level 124 → almost_full=1 on that edge, 123 → 0; level 4 → almost_empty=1, level 5 → 0.
- Flush with insert asserted at level 10 → level=0, empty=1, overflow/underflow cleared, inserted word discarded; FWFT build: single write of 0x1234 → dataOut=0x1234 after the write edge without remove.
